// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared encodings for the traffic lamp monitor slice.
//   - Lamp patterns are packed {red, yellow, green}; anything with more than
//     one bit set is a multi-lamp pattern and has no named encoding.
//   - Fault codes reported on o_fault_code.
//   - Monitor state encodings.
//   - Small pattern helpers shared by the monitor.
package traffic_pkg;

    localparam int FAULT_CODE_W = 3;

    // Lamp patterns, bit order {red, yellow, green}.
    localparam logic [2:0] PAT_OFF    = 3'b000;
    localparam logic [2:0] PAT_GREEN  = 3'b001;
    localparam logic [2:0] PAT_YELLOW = 3'b010;
    localparam logic [2:0] PAT_RED    = 3'b100;

    typedef enum logic [FAULT_CODE_W-1:0] {
        FAULT_NONE       = 3'd0,
        FAULT_MULTI      = 3'd1,
        FAULT_TRANSITION = 3'd2,
        FAULT_SHORT      = 3'd3,
        FAULT_LONG       = 3'd4,
        FAULT_DARK       = 3'd5
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_e;

    // True when two or more lamps are requested at once.
    function automatic logic is_multi(input logic [2:0] pat);
        return (pat[2] & pat[1]) | (pat[2] & pat[0]) | (pat[1] & pat[0]);
    endfunction

    // The only legal lamp-to-lamp steps: red->green->yellow->red.
    function automatic logic is_legal_step(input logic [2:0] old_pat,
                                           input logic [2:0] new_pat);
        return ((old_pat == PAT_RED)    && (new_pat == PAT_GREEN))  ||
               ((old_pat == PAT_GREEN)  && (new_pat == PAT_YELLOW)) ||
               ((old_pat == PAT_YELLOW) && (new_pat == PAT_RED));
    endfunction

endpackage

// File: rtl/traffic_flash_gen.sv
// traffic_flash_gen
// Fail-safe blink generator: FLASH_HALF cycles on, FLASH_HALF cycles off.
// o_blink is the lamp level for the cycle that follows the current clock
// edge, so the caller registers it directly into its lamp flop. The
// sequence restarts with blink=1 whenever i_run rises.
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   i_run    high while the flash should run (next-cycle request)
//   o_blink  lamp level to register at this edge
module traffic_flash_gen #(
    parameter int FLASH_HALF = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    output logic o_blink
);

    localparam int PERIOD = 2 * FLASH_HALF;
    localparam int POS_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic             run_q;
    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_next;

    // Position inside the on/off period for the coming cycle; a fresh run
    // starts at position 0, which is the first "on" cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        pos_next = '0;
        if (run_q && (pos_q != POS_W'(PERIOD - 1))) begin
            pos_next = pos_q + 1'b1;
        end
        o_blink = i_run && (pos_next < POS_W'(FLASH_HALF));
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            run_q <= 1'b0;
            pos_q <= '0;
        end else if (i_run) begin
            run_q <= 1'b1;
            pos_q <= pos_next;
        end else begin
            run_q <= 1'b0;
            pos_q <= '0;
        end
    end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor
// Safety stage behind the traffic-light FSM. Checks the requested lamp
// stream for single-lamp patterns, red->green->yellow->red order and dwell
// bounds, and forwards legal lamps registered (one cycle latency). Any
// violation latches a fault code and forces flashing yellow until cleared.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_red/i_yellow/i_green    lamp requests from the FSM
//   i_clear_fault             pulse: leave FAULT, return to IDLE
//   o_red/o_yellow/o_green    registered lamp drives
//   o_fault                   high while in FAULT
//   o_fault_code              latched cause (traffic_pkg::fault_code_e)
//   o_phase_cnt               dwell count of the current input pattern
//   o_fault_count             FAULT entries, saturating at 255
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int RED_MIN    = 2,
    parameter int RED_MAX    = 16,
    parameter int GRN_MIN    = 2,
    parameter int GRN_MAX    = 16,
    parameter int YEL_MIN    = 2,
    parameter int YEL_MAX    = 8,
    parameter int FLASH_HALF = 4,
    parameter int DWELL_W    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_red,
    input  logic                    i_yellow,
    input  logic                    i_green,
    input  logic                    i_clear_fault,
    output logic                    o_red,
    output logic                    o_yellow,
    output logic                    o_green,
    output logic                    o_fault,
    output logic [FAULT_CODE_W-1:0] o_fault_code,
    output logic [DWELL_W-1:0]      o_phase_cnt,
    output logic [7:0]              o_fault_count
);

    localparam logic [DWELL_W-1:0] CNT_SAT = '1;

    function automatic logic [DWELL_W-1:0] min_of(input logic [2:0] pat);
        case (pat)
            PAT_RED:    return DWELL_W'(RED_MIN);
            PAT_GREEN:  return DWELL_W'(GRN_MIN);
            PAT_YELLOW: return DWELL_W'(YEL_MIN);
            default:    return '0;
        endcase
    endfunction

    function automatic logic [DWELL_W-1:0] max_of(input logic [2:0] pat);
        case (pat)
            PAT_RED:    return DWELL_W'(RED_MAX);
            PAT_GREEN:  return DWELL_W'(GRN_MAX);
            PAT_YELLOW: return DWELL_W'(YEL_MAX);
            default:    return CNT_SAT;
        endcase
    endfunction

    mon_state_e         state_q, state_next;
    fault_code_e        code_q, code_next;
    logic [2:0]         pattern;
    logic [2:0]         prev_q;
    logic [DWELL_W-1:0] cnt_q, cnt_next;
    logic               same;
    logic               first_q, first_next;   // in the resync phase after IDLE
    logic               entering_fault;
    logic               blink;

    assign o_fault_code = code_q;
    assign o_phase_cnt  = cnt_q;

    traffic_flash_gen #(
        .FLASH_HALF (FLASH_HALF)
    ) u_flash (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_run   (state_next == ST_FAULT),
        .o_blink (blink)
    );

    // Next-state, fault classification and dwell counter.
    always_comb begin
        pattern    = {i_red, i_yellow, i_green};
        same       = (pattern == prev_q);
        cnt_next   = DWELL_W'(1);
        state_next = state_q;
        code_next  = FAULT_NONE;
        first_next = first_q;

        if (same) begin
            cnt_next = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Whatever phase we land in is of unknown age: skip its MIN check.
                first_next = 1'b1;
                if (is_multi(pattern)) begin
                    state_next = ST_FAULT;
                    code_next  = FAULT_MULTI;
                end else if (pattern != PAT_OFF) begin
                    state_next = ST_PASS;
                end
            end
            ST_PASS: begin
                if (!same) begin
                    // Checks in priority order; the first that fires wins.
                    // A step to all-off is classified as dark, not as an
                    // illegal transition.
                    if (is_multi(pattern)) begin
                        code_next = FAULT_MULTI;
                    end else if ((pattern != PAT_OFF) && !is_legal_step(prev_q, pattern)) begin
                        code_next = FAULT_TRANSITION;
                    end else if (!first_q && (cnt_q < min_of(prev_q))) begin
                        code_next = FAULT_SHORT;
                    end else if (pattern == PAT_OFF) begin
                        code_next = FAULT_DARK;
                    end
                end else if (cnt_q >= max_of(prev_q)) begin
                    // Holding one more cycle would make the count MAX+1.
                    code_next = FAULT_LONG;
                end

                if (code_next != FAULT_NONE) begin
                    state_next = ST_FAULT;
                end else if (!same) begin
                    first_next = 1'b0;
                end
            end
            ST_FAULT: begin
                // Inputs are ignored here; only a clear leaves, and it
                // takes priority over anything on the lamp inputs.
                code_next = code_q;
                if (i_clear_fault) begin
                    state_next = ST_IDLE;
                    code_next  = FAULT_NONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        entering_fault = (state_q != ST_FAULT) && (state_next == ST_FAULT);
    end

    // Outputs are computed from the next state so that the lamps reflect
    // the inputs sampled at the same edge (one cycle latency).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            code_q        <= FAULT_NONE;
            prev_q        <= PAT_OFF;
            cnt_q         <= '0;
            first_q       <= 1'b0;
            o_red         <= 1'b0;
            o_yellow      <= 1'b0;
            o_green       <= 1'b0;
            o_fault       <= 1'b0;
            o_fault_count <= '0;
        end else begin
            state_q  <= state_next;
            code_q   <= code_next;
            prev_q   <= pattern;
            cnt_q    <= cnt_next;
            first_q  <= first_next;
            o_red    <= (state_next == ST_PASS) && i_red;
            o_green  <= (state_next == ST_PASS) && i_green;
            o_yellow <= ((state_next == ST_PASS) && i_yellow) ||
                        ((state_next == ST_FAULT) && blink);
            o_fault  <= (state_next == ST_FAULT);
            if (entering_fault && (o_fault_count != 8'hFF)) begin
                o_fault_count <= o_fault_count + 8'd1;
            end
        end
    end

endmodule
